// File: rtl/mem_access.sv
// Memory-access stage: one instruction in flight, a valid/ready dmem request/response and load formatting.
// Optional misaligned-access trap enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_memen,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_ram_addr,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_wen,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_wen,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wmask,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    ,
    output logic            out_misalign
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [2:0]        off_q, off_d;
    logic [2:0]        ldop_q, ldop_d;
    logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
    logic              dmem_wen_q, dmem_wen_d;
    logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic [7:0]        dmem_wmask_q, dmem_wmask_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic [RD_W-1:0]   out_rd_q, out_rd_d;
    logic              out_wen_q, out_wen_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic              mis_q, mis_d;
    logic              acc_mis;
`endif

    logic [7:0]        st_base;
    logic [7:0]        st_wmask;
    logic [XLEN-1:0]   st_wdata;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_data;

    // Store lane placement: bytes shifted past the doubleword are dropped.
    always_comb begin
        case (in_op[1:0])
            2'b00:   st_base = 8'h01;
            2'b01:   st_base = 8'h03;
            2'b10:   st_base = 8'h0F;
            default: st_base = 8'hFF;
        endcase
        st_wmask = st_base << in_ram_addr[2:0];
        st_wdata = in_store_data << {in_ram_addr[2:0], 3'b000};
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    always_comb begin
        case (in_op[1:0])
            2'b00:   acc_mis = 1'b0;
            2'b01:   acc_mis = in_ram_addr[0];
            2'b10:   acc_mis = |in_ram_addr[1:0];
            default: acc_mis = |in_ram_addr[2:0];
        endcase
    end
`endif

    // Load lane extract plus sign/zero extension; doubleword ignores the unsigned bit.
    always_comb begin
        ld_shift = dmem_rdata >> {off_q, 3'b000};
        case (ldop_q[1:0])
            2'b00:   ld_data = ldop_q[2] ? {56'd0, ld_shift[7:0]}
                                         : {{56{ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = ldop_q[2] ? {48'd0, ld_shift[15:0]}
                                         : {{48{ld_shift[15]}}, ld_shift[15:0]};
            2'b10:   ld_data = ldop_q[2] ? {32'd0, ld_shift[31:0]}
                                         : {{32{ld_shift[31]}}, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        ldop_d       = ldop_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wen_d   = dmem_wen_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_wmask_d = dmem_wmask_q;
        out_data_d   = out_data_q;
        out_rd_d     = out_rd_q;
        out_wen_d    = out_wen_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        mis_d        = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    off_d    = in_ram_addr[2:0];
                    ldop_d   = in_op[2:0];
                    out_rd_d = in_rd;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    mis_d    = 1'b0;
`endif
                    if (!in_memen) begin
                        out_data_d = in_alu_result;
                        out_wen_d  = in_wen;
                        state_d    = S_HOLD;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    end else if (acc_mis) begin
                        out_data_d = in_ram_addr;
                        out_wen_d  = 1'b0;
                        mis_d      = 1'b1;
                        state_d    = S_HOLD;
`endif
                    end else begin
                        dmem_addr_d  = {in_ram_addr[XLEN-1:3], 3'b000};
                        dmem_wen_d   = in_op[3];
                        dmem_wdata_d = st_wdata;
                        dmem_wmask_d = st_wmask;
                        out_data_d   = '0;
                        out_wen_d    = in_op[3] ? 1'b0 : in_wen;
                        state_d      = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dmem_resp_valid) begin
                    if (!dmem_wen_q) out_data_d = ld_data;
                    state_d = S_HOLD;
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            off_q        <= '0;
            ldop_q       <= '0;
            dmem_addr_q  <= '0;
            dmem_wen_q   <= 1'b0;
            dmem_wdata_q <= '0;
            dmem_wmask_q <= '0;
            out_data_q   <= '0;
            out_rd_q     <= '0;
            out_wen_q    <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            mis_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            ldop_q       <= ldop_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_wmask_q <= dmem_wmask_d;
            out_data_q   <= out_data_d;
            out_rd_q     <= out_rd_d;
            out_wen_q    <= out_wen_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            mis_q        <= mis_d;
`endif
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign dmem_req_valid = (state_q == S_REQ);
    assign out_valid      = (state_q == S_HOLD);
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wen       = dmem_wen_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_wmask     = dmem_wmask_q;
    assign out_data       = out_data_q;
    assign out_rd         = out_rd_q;
    assign out_wen        = out_wen_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign out_misalign   = mis_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed plus random bench for mem_access against a byte-lane reference model.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_memen, in_wen;
    logic [3:0]  in_op;
    logic [63:0] in_alu_result, in_ram_addr, in_store_data;
    logic [4:0]  in_rd;
    logic        dmem_req_valid, dmem_req_ready, dmem_wen, dmem_resp_valid;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wmask;
    logic        out_valid, out_ready, out_wen;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        out_misalign;
`endif

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_memen(in_memen), .in_op(in_op),
        .in_alu_result(in_alu_result), .in_ram_addr(in_ram_addr),
        .in_store_data(in_store_data), .in_rd(in_rd), .in_wen(in_wen),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        , .out_misalign(out_misalign)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: pick size bytes at the lane offset, then extend by the unsigned bit.
    function automatic logic [63:0] ld_model(input logic [63:0] rdata, input logic [3:0] op,
                                             input int off);
        logic [63:0] t, m;
        int nb;
        nb = 1 << op[1:0];
        t  = rdata >> (off * 8);
        m  = (nb == 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1);
        t  = t & m;
        if (!op[2] && nb < 8 && t[nb*8-1]) t = t | ~m;
        return t;
    endfunction

    task automatic run_op(input logic memen, input logic [3:0] op, input logic [63:0] alu,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [4:0] rd, input logic wen, input logic [63:0] rdata,
                          input int rq, input int rs, input int od);
        logic [63:0] e_addr, e_wdata, e_data;
        logic [7:0]  e_mask;
        logic        e_wen, mis;
        int          off, nb, e_lat, edges;
        off = int'(addr[2:0]);
        nb  = 1 << op[1:0];
        mis = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        mis = memen && ((addr % 64'(nb)) != 0);
`endif
        e_addr  = addr & ~64'h7;
        e_wdata = sdata << (off * 8);
        e_mask  = 8'(((1 << nb) - 1) << off);
        if (!memen)     e_data = alu;
        else if (mis)   e_data = addr;
        else if (op[3]) e_data = 64'd0;
        else            e_data = ld_model(rdata, op, off);
        e_wen = (!memen) ? wen : (mis || op[3]) ? 1'b0 : wen;
        e_lat = 1 + ((memen && !mis) ? 2 + rq + rs : 0);

        chk("idle_ready", in_ready, 1);
        in_memen = memen; in_op = op; in_alu_result = alu; in_ram_addr = addr;
        in_store_data = sdata; in_rd = rd; in_wen = wen; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_alu_result = $urandom; in_ram_addr = {$urandom, $urandom};
        edges = 0;
        chk("busy_ready", in_ready, 0);
        if (memen && !mis) begin
            // Junk responses while in REQ must be ignored.
            dmem_resp_valid = 1'b1;
            dmem_rdata = {$urandom, $urandom};
            for (int i = 0; i <= rq; i++) begin
                dmem_req_ready = (i == rq);
                chk("req_valid", dmem_req_valid, 1);
                chk("req_addr", dmem_addr, e_addr);
                chk("req_wen", dmem_wen, op[3]);
                chk("req_wdata", dmem_wdata, e_wdata);
                chk("req_wmask", dmem_wmask, e_mask);
                chk("busy_ready", in_ready, 0);
                @(posedge clk); #1;
                edges++;
            end
            dmem_req_ready = 1'b0;
            dmem_resp_valid = 1'b0;
            chk("wait_req_low", dmem_req_valid, 0);
            for (int i = 0; i < rs; i++) begin
                @(posedge clk); #1;
                edges++;
                chk("early_out_valid", out_valid, 0);
            end
            dmem_rdata = rdata;
            dmem_resp_valid = 1'b1;
            @(posedge clk); #1;
            edges++;
            dmem_resp_valid = 1'b0;
            dmem_rdata = {$urandom, $urandom};
        end else begin
            chk("no_req", dmem_req_valid, 0);
        end
        chk("latency", 64'(edges + 1), 64'(e_lat));
        dmem_resp_valid = 1'b1;
        for (int i = 0; i <= od; i++) begin
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, e_data);
            chk("out_rd", out_rd, rd);
            chk("out_wen", out_wen, e_wen);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            chk("out_misalign", out_misalign, mis);
`endif
            chk("hold_req_low", dmem_req_valid, 0);
            out_ready = (i == od);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        dmem_resp_valid = 1'b0;
        chk("out_done", out_valid, 0);
        chk("back_idle", in_ready, 1);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 0; in_memen = 0; in_op = 0; in_alu_result = 0; in_ram_addr = 0;
        in_store_data = 0; in_rd = 0; in_wen = 0;
        dmem_req_ready = 0; dmem_resp_valid = 0; dmem_rdata = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", dmem_req_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dmem_wmask", dmem_wmask, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_op(0, 4'b0000, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 64'h0, 0, 0, 0);
        run_op(1, 4'b0000, 64'h0, 64'h1003, 64'h0, 5'd7, 1'b1, 64'h0000_0000_8000_0000, 0, 0, 0);
        run_op(1, 4'b0100, 64'h0, 64'h1003, 64'h0, 5'd7, 1'b1, 64'h0000_0000_8000_0000, 0, 0, 0);
        run_op(1, 4'b1001, 64'h0, 64'h2002, 64'hABCD, 5'd3, 1'b1, 64'h0, 0, 0, 0);
        run_op(1, 4'b0011, 64'h0, 64'h4000, 64'h0, 5'd9, 1'b1, 64'hDEAD_BEEF_0123_4567, 4, 1, 3);
        run_op(1, 4'b0010, 64'h0, 64'h5004, 64'h0, 5'd0, 1'b1, 64'h8765_4321_0000_0000, 0, 2, 0);
        run_op(1, 4'b1011, 64'h0, 64'h6000, 64'h1122_3344_5566_7788, 5'd1, 1'b1, 64'h0, 1, 0, 1);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        run_op(1, 4'b0010, 64'h0, 64'h3002, 64'h0, 5'd4, 1'b1, 64'h0, 0, 0, 0);
`endif

        // Async reset while waiting for a response; the late response must be ignored.
        in_memen = 1; in_op = 4'b0011; in_ram_addr = 64'h7000; in_rd = 5'd6; in_wen = 1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        chk("in_wait", dmem_req_valid, 0);
        rst = 1'b0;
        #2;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_req_valid", dmem_req_valid, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_wen", out_wen, 0);
        chk("midrst_wmask", dmem_wmask, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        dmem_resp_valid = 1'b1;
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_resp_out_valid", out_valid, 0);
            chk("late_resp_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            logic        m;
            logic [3:0]  op;
            m  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom);
            run_op(m, op, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom), 1'($urandom), {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result, the memory address and store data produced by execute, and performs at most one data-memory transaction per instruction over a valid/ready request and response interface.
- Formats load data (lane extract plus sign/zero extend) and hands a write-back record to the write-back stage.
- Strictly one instruction in flight; no pipelining inside the block.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  block can accept an instruction; high only in IDLE.
- in_memen  in  1  1 = memory op, 0 = pass-through of ALU result.
- in_op  in  4  [3] store, [2] unsigned load, [1:0] size (00 B, 01 H, 10 W, 11 D).
- in_alu_result  in  64  execute result, used for pass-through.
- in_ram_addr  in  64  byte address from execute.
- in_store_data  in  64  store source (rs2 value).
- in_rd  in  5  destination register.
- in_wen  in  1  register write enable.
- dmem_req_valid  out  1  request pending.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  64  {in_ram_addr[63:3], 3'b000}.
- dmem_wen  out  1  1 = write.
- dmem_wdata  out  64  lane-shifted store data.
- dmem_wmask  out  8  byte enables.
- dmem_resp_valid  in  1  response or write acknowledge.
- dmem_rdata  in  64  read data (aligned doubleword).
- out_valid  out  1  write-back record valid.
- out_ready  in  1  write-back accepts.
- out_data  out  64  result.
- out_rd  out  5  destination register.
- out_wen  out  1  register write enable.

Behaviour:
- Reset (rst=0, async): state=IDLE; all latched fields, out_*, and dmem_* registered outputs = 0. in_ready=1 while in reset; it is combinational from state==IDLE.
- FSM states:
  - IDLE: on in_valid&in_ready, latch all in_* fields. Go to REQ if in_memen=1, else HOLD with out_data=in_alu_result.
  - REQ: dmem_req_valid=1. addr/wen/wdata/wmask stay stable until dmem_req_ready. On handshake, go to WAIT.
  - WAIT: dmem_req_valid=0. On dmem_resp_valid, capture formatted data and go to HOLD. dmem_resp_valid outside WAIT is ignored.
  - HOLD: out_valid=1; out_* stay stable until out_ready. On out_valid&out_ready, go to IDLE. No bypass back to IDLE within the same cycle.
- Latency from the accept edge:
  - Pass-through: out_valid 1 cycle later.
  - Memory op with zero-wait memory (ready in REQ, response in the first WAIT cycle): out_valid 3 cycles later.
- Lane offset: off=ram_addr[2:0]; shift=off*8.
- Store:
  - dmem_wdata = store_data << shift.
  - dmem_wmask = (B 0x01, H 0x03, W 0x0F, D 0xFF) << off, truncated to 8 bits; bytes past the doubleword are dropped.
  - Write-back: out_wen forced 0, out_data=0.
- Load:
  - t = dmem_rdata >> shift.
  - Take t[7:0], t[15:0], t[31:0] or t[63:0] per size; sign-extend when op[2]=0, zero-extend when op[2]=1. D ignores op[2].
  - out_wen = latched in_wen.
- Writes to rd=0 pass through with out_wen unchanged; the register file discards them.
- Reset mid-transaction: immediate return to IDLE with dmem_req_valid=0. A response arriving after reset release is ignored (state≠WAIT).

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - Adds output out_misalign (1 bit, reset 0).
  - An access is misaligned when ram_addr mod size-bytes ≠ 0.
  - A misaligned access issues no request and goes IDLE→HOLD directly with out_misalign=1, out_wen=0, out_data=ram_addr.
  - out_misalign=0 for all other records.
- Undefined: no out_misalign port; misaligned accesses proceed with the truncated-mask and shift rules above.

Test Plan:
- Pass-through: in_memen=0, alu_result=0x1234, rd=5, wen=1 -> out_valid next cycle, out_data=0x1234, out_rd=5; no dmem_req_valid.
- LB sign: addr=0x1003, rdata=0x0000_0000_8000_0000 -> lane byte 0x80 -> out_data=0xFFFF_FFFF_FFFF_FF80. Same with LBU -> 0x80.
- SH: addr=0x2002, store_data=0xABCD -> dmem_addr=0x2000, wmask=0x0C, wdata=0x0000_0000_ABCD_0000, out_wen=0.
- Backpressure: dmem_req_ready low 4 cycles, then out_ready low 3 cycles -> request fields stable, in_ready=0 throughout, then exactly one out handshake.
- Async reset asserted in WAIT, response arrives 2 cycles after release -> state IDLE, out_valid stays 0.
- With MEM_ACCESS_MISALIGN_TRAP_EN: LW at 0x3002 -> no dmem_req_valid, out_misalign=1, out_data=0x3002, out_wen=0.
